// File: rtl/cpu_lsu_if.sv
// Bundle of the CPU-side request/response and the data-memory port of cpu_lsu.
// The slave modport is the load/store unit; the master modport is its environment
// (CPU control plus memory).
interface cpu_lsu_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = XLEN / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic [4:0]        req_rd;

  logic              rsp_valid;
  logic [XLEN-1:0]   rsp_rdata;
  logic [4:0]        rsp_rd;
  logic              rsp_err;
  logic [1:0]        rsp_err_code;

  logic              mem_en;
  logic [NB-1:0]     mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN-1:0]   mem_rdata;
  logic              mem_ack;

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
    output mem_rdata, mem_ack,
    input  req_ready, rsp_valid, rsp_rdata, rsp_rd, rsp_err, rsp_err_code,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
    input  mem_rdata, mem_ack,
    output req_ready, rsp_valid, rsp_rdata, rsp_rd, rsp_err, rsp_err_code,
    output mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cpu_lsu.sv
// Load/store unit: decodes RV funct3 size/sign, aligns store data onto byte lanes,
// extracts and extends load data, and runs one wait-state bus cycle per request with
// a timeout. Illegal and misaligned requests are answered without touching the bus.
module cpu_lsu #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic      aclk,
  input  logic      aresetn,
  cpu_lsu_if.slave  bus
);
  localparam int NB = XLEN / 8;
  localparam int LW = $clog2(NB);
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT < 1) ? '0 : CW'(TIMEOUT - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]        state;
  logic [CW-1:0]     wait_cnt;
  logic [LW-1:0]     lane_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic              store_q;
  logic [4:0]        rd_q;

  logic              mem_en_q;
  logic [NB-1:0]     mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [XLEN-1:0]   mem_wdata_q;

  logic [XLEN-1:0]   rsp_rdata_q;
  logic [4:0]        rsp_rd_q;
  logic              rsp_err_q;
  logic [1:0]        rsp_code_q;

  logic              req_legal;
  logic              req_misal;
  logic [1:0]        req_size;
  logic [LW-1:0]     req_lane;
  logic              ack_hit;
  logic              timeout_hit;

  // Legality of a funct3 code for the given direction and data width.
  function automatic logic is_legal(input logic store, input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b000, 3'b001, 3'b010: ok = 1'b1;
      3'b011:                 ok = (XLEN == 64);
      3'b100, 3'b101:         ok = !store;
      3'b110:                 ok = !store && (XLEN == 64);
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Natural alignment check; byte accesses are always aligned.
  function automatic logic is_misaligned(input logic [2:0] a, input logic [1:0] sz);
    logic bad;
    case (sz)
      2'd0:    bad = 1'b0;
      2'd1:    bad = a[0];
      2'd2:    bad = |a[1:0];
      default: bad = |a;
    endcase
    return bad;
  endfunction

  // Access size in bytes, clamped to the bus width.
  function automatic int size_bytes(input logic [1:0] sz);
    int n;
    n = 1 << sz;
    if (n > NB) n = NB;
    return n;
  endfunction

  // Byte-enable mask: size bytes starting at the lane.
  function automatic logic [NB-1:0] we_mask(input logic [LW-1:0] lane, input logic [1:0] sz);
    logic [NB-1:0] m;
    int n;
    n = size_bytes(sz);
    for (int i = 0; i < NB; i++) begin
      m[i] = (i >= int'(lane)) && (i < int'(lane) + n);
    end
    return m;
  endfunction

  // Low size bytes of the store data repeated across every lane.
  function automatic logic [XLEN-1:0] replicate(input logic [XLEN-1:0] wd, input logic [1:0] sz);
    logic [XLEN-1:0] r;
    int n;
    n = size_bytes(sz);
    for (int i = 0; i < NB; i++) begin
      r[8*i +: 8] = wd[8*(i % n) +: 8];
    end
    return r;
  endfunction

  // Pull size bytes from the lane and sign- or zero-extend to XLEN.
  function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] raw, input logic [LW-1:0] lane,
                                              input logic [1:0] sz, input logic uns);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] r;
    int nbits;
    sh    = raw >> {lane, 3'b000};
    nbits = 8 * size_bytes(sz);
    for (int i = 0; i < XLEN; i++) begin
      r[i] = (i < nbits) ? sh[i] : (uns ? 1'b0 : sh[nbits-1]);
    end
    return r;
  endfunction

  assign req_size    = bus.req_funct3[1:0];
  assign req_lane    = bus.req_addr[LW-1:0];
  assign req_legal   = is_legal(bus.req_store, bus.req_funct3);
  assign req_misal   = is_misaligned(bus.req_addr[2:0], req_size);
  assign ack_hit     = (state == ACCESS) && bus.mem_ack;
  assign timeout_hit = (state == ACCESS) && !bus.mem_ack && (TIMEOUT != 0) && (wait_cnt == TO_LAST);

  assign bus.req_ready    = (state == IDLE);
  assign bus.rsp_valid    = (state == RESP);
  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.rsp_rd       = rsp_rd_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.rsp_err_code = rsp_code_q;
  assign bus.mem_en       = mem_en_q && (state == ACCESS);
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;

  // Request acceptance, bus cycle with wait counter, and one-cycle response.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      lane_q      <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      store_q     <= 1'b0;
      rd_q        <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_rdata_q <= '0;
      rsp_rd_q    <= '0;
      rsp_err_q   <= 1'b0;
      rsp_code_q  <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            if (!req_legal || req_misal) begin
              rsp_rdata_q <= '0;
              rsp_rd_q    <= '0;
              rsp_err_q   <= 1'b1;
              rsp_code_q  <= !req_legal ? 2'b11 : 2'b01;
              state       <= RESP;
            end else begin
              lane_q      <= req_lane;
              size_q      <= req_size;
              uns_q       <= bus.req_funct3[2];
              store_q     <= bus.req_store;
              rd_q        <= bus.req_rd;
              wait_cnt    <= '0;
              mem_en_q    <= 1'b1;
              mem_addr_q  <= {bus.req_addr[ADDR_W-1:LW], {LW{1'b0}}};
              mem_we_q    <= bus.req_store ? we_mask(req_lane, req_size) : '0;
              mem_wdata_q <= bus.req_store ? replicate(bus.req_wdata, req_size) : '0;
              state       <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (ack_hit) begin
            rsp_rdata_q <= store_q ? '0 : extract(bus.mem_rdata, lane_q, size_q, uns_q);
            rsp_rd_q    <= store_q ? 5'd0 : rd_q;
            rsp_err_q   <= 1'b0;
            rsp_code_q  <= 2'b00;
            mem_en_q    <= 1'b0;
            state       <= RESP;
          end else if (timeout_hit) begin
            rsp_rdata_q <= '0;
            rsp_rd_q    <= '0;
            rsp_err_q   <= 1'b1;
            rsp_code_q  <= 2'b10;
            mem_en_q    <= 1'b0;
            state       <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          mem_en_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_lsu.sv
// Bench for cpu_lsu: a 32-bit instance (short timeout) and a 64-bit instance share
// one stimulus path selected by 'sel'; results are compared against a reference model.
module tb_cpu_lsu;
  localparam int T32 = 4;
  localparam int T64 = 6;

  logic        aclk;
  logic        aresetn;
  logic        sel;
  logic        req_valid;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic [4:0]  req_rd;
  logic [63:0] mem_rdata;
  logic        mem_ack;

  int total = 0;
  int bad   = 0;

  cpu_lsu_if #(.XLEN(32), .ADDR_W(32)) b32 ();
  cpu_lsu_if #(.XLEN(64), .ADDR_W(32)) b64 ();

  cpu_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT(T32)) dut32 (.aclk(aclk), .aresetn(aresetn), .bus(b32));
  cpu_lsu #(.XLEN(64), .ADDR_W(32), .TIMEOUT(T64)) dut64 (.aclk(aclk), .aresetn(aresetn), .bus(b64));

  assign b32.req_valid  = req_valid & ~sel;
  assign b32.req_store  = req_store;
  assign b32.req_funct3 = req_funct3;
  assign b32.req_addr   = req_addr;
  assign b32.req_wdata  = req_wdata[31:0];
  assign b32.req_rd     = req_rd;
  assign b32.mem_rdata  = mem_rdata[31:0];
  assign b32.mem_ack    = mem_ack & ~sel;

  assign b64.req_valid  = req_valid & sel;
  assign b64.req_store  = req_store;
  assign b64.req_funct3 = req_funct3;
  assign b64.req_addr   = req_addr;
  assign b64.req_wdata  = req_wdata;
  assign b64.req_rd     = req_rd;
  assign b64.mem_rdata  = mem_rdata;
  assign b64.mem_ack    = mem_ack & sel;

  logic        o_ready, o_rvalid, o_err, o_en;
  logic [63:0] o_rdata, o_wdata;
  logic [4:0]  o_rd;
  logic [1:0]  o_code;
  logic [7:0]  o_we;
  logic [31:0] o_addr;

  assign o_ready  = sel ? b64.req_ready    : b32.req_ready;
  assign o_rvalid = sel ? b64.rsp_valid    : b32.rsp_valid;
  assign o_rdata  = sel ? b64.rsp_rdata    : {32'h0, b32.rsp_rdata};
  assign o_rd     = sel ? b64.rsp_rd       : b32.rsp_rd;
  assign o_err    = sel ? b64.rsp_err      : b32.rsp_err;
  assign o_code   = sel ? b64.rsp_err_code : b32.rsp_err_code;
  assign o_en     = sel ? b64.mem_en       : b32.mem_en;
  assign o_we     = sel ? b64.mem_we       : {4'h0, b32.mem_we};
  assign o_addr   = sel ? b64.mem_addr     : b32.mem_addr;
  assign o_wdata  = sel ? b64.mem_wdata    : {32'h0, b32.mem_wdata};

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour from the architectural rules.
  function automatic void model(input int xlen, input logic st, input logic [2:0] f,
                                input logic [31:0] a, input logic [63:0] wd, input logic [63:0] rdat,
                                output logic [1:0] code, output logic [7:0] we,
                                output logic [63:0] wrep, output logic [63:0] ld,
                                output logic [31:0] maddr);
    bit legal;
    int size, nb, lane, bits;
    logic [63:0] mask, v;
    if (st) legal = (f <= 3'd2) || (f == 3'd3 && xlen == 64);
    else    legal = (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || ((f == 3'd3 || f == 3'd6) && xlen == 64);
    size  = 1 << f[1:0];
    nb    = xlen / 8;
    lane  = int'(a % 32'(nb));
    code  = !legal ? 2'b11 : ((a % 32'(size)) != 0) ? 2'b01 : 2'b00;
    we    = st ? 8'(((1 << size) - 1) << lane) : 8'h00;
    wrep  = 64'h0;
    if (st) begin
      for (int i = 0; i < nb; i++) wrep = wrep | (((wd >> (8 * (i % size))) & 64'hFF) << (8 * i));
    end
    bits = size * 8;
    mask = (bits == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << bits) - 64'd1);
    v    = (rdat >> (8 * lane)) & mask;
    if (!f[2] && v[bits-1]) v = v | ~mask;
    if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    ld    = v;
    maddr = a - 32'(lane);
  endfunction

  // One request; entered and left #1 after a rising edge with the unit idle.
  task automatic run_op(input logic st, input logic [2:0] f, input logic [31:0] a,
                        input logic [63:0] wd, input logic [4:0] r, input logic [63:0] rdat,
                        input int waits);
    int xlen, tmo, k;
    bit done;
    logic [1:0]  code;
    logic [7:0]  we;
    logic [63:0] wrep, ld, erd_data;
    logic [31:0] maddr;
    logic [4:0]  erd;
    xlen = sel ? 64 : 32;
    tmo  = sel ? T64 : T32;
    model(xlen, st, f, a, wd, rdat, code, we, wrep, ld, maddr);
    chk("ready_idle", {63'h0, o_ready}, 64'd1);
    req_store = st; req_funct3 = f; req_addr = a; req_wdata = wd; req_rd = r;
    req_valid = 1'b1;
    @(posedge aclk); #1;
    req_valid  = 1'b0;
    req_store  = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = {$urandom, $urandom};
    req_rd     = 5'($urandom);
    if (code != 2'b00) begin
      chk("rej_mem_en", {63'h0, o_en}, 64'd0);
      chk("rej_rsp_valid", {63'h0, o_rvalid}, 64'd1);
      chk("rej_err", {63'h0, o_err}, 64'd1);
      chk("rej_code", {62'h0, o_code}, {62'h0, code});
      chk("rej_rdata", o_rdata, 64'd0);
      chk("rej_rd", {59'h0, o_rd}, 64'd0);
      erd_data = 64'd0; erd = 5'd0;
    end else begin
      k = 0; done = 0;
      while (!done) begin
        chk("acc_mem_en", {63'h0, o_en}, 64'd1);
        chk("acc_rsp_valid", {63'h0, o_rvalid}, 64'd0);
        chk("acc_mem_addr", {32'h0, o_addr}, {32'h0, maddr});
        chk("acc_mem_we", {56'h0, o_we}, {56'h0, we});
        if (st) chk("acc_mem_wdata", o_wdata, wrep);
        if (k == waits) begin
          mem_ack = 1'b1; mem_rdata = rdat;
        end else begin
          mem_ack = 1'b0; mem_rdata = {$urandom, $urandom};
        end
        @(posedge aclk); #1;
        mem_ack = 1'b0;
        mem_rdata = {$urandom, $urandom};
        k++;
        if (k > waits || k == tmo) done = 1;
      end
      chk("end_mem_en", {63'h0, o_en}, 64'd0);
      chk("end_rsp_valid", {63'h0, o_rvalid}, 64'd1);
      if (waits < tmo) begin
        erd_data = st ? 64'd0 : ld;
        erd      = st ? 5'd0 : r;
        chk("ok_err", {63'h0, o_err}, 64'd0);
        chk("ok_code", {62'h0, o_code}, 64'd0);
      end else begin
        erd_data = 64'd0;
        erd      = 5'd0;
        chk("to_err", {63'h0, o_err}, 64'd1);
        chk("to_code", {62'h0, o_code}, 64'd2);
      end
      chk("rsp_rdata", o_rdata, erd_data);
      chk("rsp_rd", {59'h0, o_rd}, {59'h0, erd});
    end
    @(posedge aclk); #1;
    chk("post_rsp_valid", {63'h0, o_rvalid}, 64'd0);
    chk("post_ready", {63'h0, o_ready}, 64'd1);
    chk("hold_rdata", o_rdata, erd_data);
    chk("hold_rd", {59'h0, o_rd}, {59'h0, erd});
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_ready"}, {63'h0, o_ready}, 64'd1);
    chk({tag, "_mem_en"}, {63'h0, o_en}, 64'd0);
    chk({tag, "_mem_we"}, {56'h0, o_we}, 64'd0);
    chk({tag, "_mem_addr"}, {32'h0, o_addr}, 64'd0);
    chk({tag, "_mem_wdata"}, o_wdata, 64'd0);
    chk({tag, "_rsp_valid"}, {63'h0, o_rvalid}, 64'd0);
    chk({tag, "_rsp_rdata"}, o_rdata, 64'd0);
    chk({tag, "_rsp_rd"}, {59'h0, o_rd}, 64'd0);
    chk({tag, "_rsp_err"}, {63'h0, o_err}, 64'd0);
    chk({tag, "_rsp_code"}, {62'h0, o_code}, 64'd0);
  endtask

  initial begin
    aresetn = 1'b0; sel = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 64'h0; req_rd = 5'd0; mem_rdata = 64'h0; mem_ack = 1'b0;
    #1;
    reset_checks("rst32");
    sel = 1'b1; #1;
    reset_checks("rst64");
    sel = 1'b0;
    @(negedge aclk); aresetn = 1'b1;
    @(posedge aclk); #1;

    // 32-bit directed cases
    run_op(1'b1, 3'b010, 32'h100, 64'hDEADBEEF, 5'd7, 64'h0, 3);
    run_op(1'b0, 3'b000, 32'h103, 64'h0, 5'd5, 64'h80FF1234, 0);
    run_op(1'b0, 3'b100, 32'h103, 64'h0, 5'd5, 64'h80FF1234, 0);
    run_op(1'b0, 3'b001, 32'h102, 64'h0, 5'd6, 64'h80FF1234, 1);
    run_op(1'b0, 3'b101, 32'h102, 64'h0, 5'd6, 64'h80FF1234, 0);
    run_op(1'b1, 3'b001, 32'h102, 64'h1234ABCD, 5'd3, 64'h0, 1);
    run_op(1'b1, 3'b000, 32'h101, 64'h000000A5, 5'd3, 64'h0, 2);
    run_op(1'b0, 3'b010, 32'h102, 64'h0, 5'd4, 64'h0, 0);
    run_op(1'b0, 3'b011, 32'h100, 64'h0, 5'd4, 64'h0, 0);
    run_op(1'b0, 3'b011, 32'h101, 64'h0, 5'd4, 64'h0, 0);
    run_op(1'b1, 3'b100, 32'h100, 64'h11, 5'd4, 64'h0, 0);
    run_op(1'b0, 3'b111, 32'h100, 64'h0, 5'd4, 64'h0, 0);
    run_op(1'b0, 3'b010, 32'h104, 64'h0, 5'd8, 64'h12345678, 10);
    run_op(1'b0, 3'b010, 32'h104, 64'h0, 5'd8, 64'h12345678, 3);

    // Stray ack while idle must do nothing
    mem_ack = 1'b1;
    @(posedge aclk); #1;
    mem_ack = 1'b0;
    chk("stray_rsp_valid", {63'h0, o_rvalid}, 64'd0);
    chk("stray_mem_en", {63'h0, o_en}, 64'd0);
    chk("stray_ready", {63'h0, o_ready}, 64'd1);

    // Reset in the middle of an access
    req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h200; req_rd = 5'd9; req_valid = 1'b1;
    @(posedge aclk); #1;
    req_valid = 1'b0;
    chk("mid_mem_en", {63'h0, o_en}, 64'd1);
    #2;
    aresetn = 1'b0;
    #1;
    chk("mid_rst_mem_en", {63'h0, o_en}, 64'd0);
    chk("mid_rst_ready", {63'h0, o_ready}, 64'd1);
    chk("mid_rst_rsp_valid", {63'h0, o_rvalid}, 64'd0);
    @(negedge aclk); aresetn = 1'b1;
    mem_ack = 1'b1;
    @(posedge aclk); #1;
    mem_ack = 1'b0;
    chk("after_rst_rsp_valid", {63'h0, o_rvalid}, 64'd0);
    chk("after_rst_mem_en", {63'h0, o_en}, 64'd0);
    @(posedge aclk); #1;
    chk("after_rst_rsp_valid2", {63'h0, o_rvalid}, 64'd0);

    // 32-bit randomized
    for (int i = 0; i < 40; i++) begin
      run_op(1'($urandom), 3'($urandom), 32'h1000 + $urandom_range(0, 15),
             {$urandom, $urandom}, 5'($urandom), {$urandom, $urandom}, $urandom_range(0, 5));
    end

    // 64-bit instance
    sel = 1'b1; #1;
    chk("sel64_ready", {63'h0, o_ready}, 64'd1);
    run_op(1'b0, 3'b011, 32'h208, 64'h0, 5'd9, 64'h8877665544332211, 0);
    run_op(1'b1, 3'b011, 32'h208, 64'hCAFEF00D12345678, 5'd9, 64'h0, 2);
    run_op(1'b0, 3'b110, 32'h204, 64'h0, 5'd10, 64'h8877665544332211, 1);
    run_op(1'b0, 3'b010, 32'h204, 64'h0, 5'd10, 64'h8877665544332211, 0);
    run_op(1'b1, 3'b010, 32'h20C, 64'h00000000A1B2C3D4, 5'd1, 64'h0, 0);
    run_op(1'b0, 3'b011, 32'h20C, 64'h0, 5'd1, 64'h0, 0);
    run_op(1'b0, 3'b011, 32'h210, 64'h0, 5'd2, 64'h0, 9);
    for (int i = 0; i < 40; i++) begin
      run_op(1'($urandom), 3'($urandom), 32'h2000 + $urandom_range(0, 15),
             {$urandom, $urandom}, 5'($urandom), {$urandom, $urandom}, $urandom_range(0, 7));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cpu_lsu.md
# cpu_lsu

Parametrised load/store unit between the CPU control FSM and the data-memory port. It accepts one load or store per handshake and decodes RV funct3 size/sign. It performs lane alignment, byte-enable generation and sign/zero extension, and runs a wait-state memory transaction with an `mem_ack` handshake. It reports misaligned, illegal-size and timeout errors instead of issuing bad bus cycles.

## Interface
- `XLEN`, 32: data width, 32 or 64; lanes `NB = XLEN/8`.
- `ADDR_W`, 32: byte-address width.
- `TIMEOUT`, 255: maximum cycles `mem_en` stays high without `mem_ack`; 0 disables the timeout.

- `aclk` in 1: clock; all state updates on rising edge.
- `aresetn` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept; equals (state == IDLE).
- `req_store` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV size/sign code.
- `req_addr` in `ADDR_W`: byte address.
- `req_wdata` in `XLEN`: store data, right-aligned.
- `req_rd` in 5: load destination register.
- `rsp_valid` out 1: one-cycle completion pulse; no backpressure.
- `rsp_rdata` out `XLEN`: extended load data; 0 for stores and errors.
- `rsp_rd` out 5: `req_rd` for a successful load, else 0.
- `rsp_err` out 1: error flag.
- `rsp_err_code` out 2: 00 none, 01 misaligned, 10 timeout, 11 illegal funct3.
- `mem_en` out 1: bus cycle active.
- `mem_we` out `NB`: byte write enables; all 0 for loads.
- `mem_addr` out `ADDR_W`: `req_addr` with low log2(NB) bits cleared.
- `mem_wdata` out `XLEN`: lane-replicated store data.
- `mem_rdata` in `XLEN`: read data, valid when `mem_ack`=1.
- `mem_ack` in 1: completes the current bus cycle.

## Operation
- **funct3 decode:**
  - 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
  - 011 LD/SD and 110 LWU are legal only when `XLEN`=64.
  - Stores are legal only for 000/001/010/011.
  - Everything else is illegal.
- **Alignment:** half requires `addr[0]`=0; word requires `addr[1:0]`=0; double requires `addr[2:0]`=0. Bytes are always aligned.
- **Lane:** `lane = addr[log2(NB)-1:0]`.
- **Store encoding:**
  - `mem_we` = size mask (1, 3, F, FF) shifted left by `lane`.
  - `mem_wdata` = low size bytes of `req_wdata` replicated across all lanes.
- **Load extraction:** size bytes taken from `mem_rdata` starting at `lane`, sign-extended (LB/LH/LW) or zero-extended (LBU/LHU/LWU) to `XLEN`.
- **FSM states:** IDLE, ACCESS, RESP.
  - IDLE → RESP with an error code when `req_valid` is set and the request is illegal (code 11) or misaligned (code 01). Illegal takes priority. No bus cycle is issued.
  - IDLE → ACCESS when `req_valid` is set and the request is legal. All bus fields and `rd` are latched.
  - ACCESS: `mem_en`=1 with `mem_addr`/`mem_we`/`mem_wdata` held stable.
    - On `mem_ack`: capture the extracted load data → RESP, error 00.
    - If the wait counter reaches `TIMEOUT` with no ack: → RESP, error 10, `rsp_rdata`=0, `rsp_rd`=0.
  - RESP: `rsp_valid`=1 for exactly one cycle → IDLE.
- **Wait counter:**
  - Width is clog2(`TIMEOUT`+1).
  - Cleared on entry to ACCESS; increments every ACCESS cycle without ack.
  - Abort when the counter equals `TIMEOUT`-1 and no ack arrives that cycle, so `mem_en` is high for exactly `TIMEOUT` cycles.
  - An ack arriving in the final cycle wins over the timeout.
- **Response outputs** are registered and change only on entry to RESP. They hold their last value otherwise; only `rsp_valid` pulses.

## Timing
- **Reset** (asynchronous, immediate):
  - State = IDLE, so `req_ready`=1.
  - `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_rd`=0, `rsp_err`=0, `rsp_err_code`=0.
- **Reset mid-operation:** an in-flight access is dropped with no response, and `mem_en` falls without waiting for a clock edge.
- **Accepted access** (request accepted at edge 0):
  - `mem_en` rises after edge 0.
  - An ack at the first ACCESS cycle means `rsp_valid` is high in the cycle after edge 1.
  - Minimum request-to-response latency is 2 cycles; each wait cycle adds 1.
- **Rejected request:** `rsp_valid` is high in the cycle after the accepting edge (latency 1).
- **Throughput:** `req_ready`=0 from acceptance through RESP, so a new request can be accepted in the cycle after `rsp_valid`.
- **Stray acks:** `mem_ack` is ignored outside ACCESS.
- **Request inputs** are sampled only in IDLE; their changes in other states have no effect.

## Test plan
1. **SW with wait states:** SW 0xDEADBEEF to 0x100, `mem_ack` after 3 wait cycles.
   → `mem_en` high 3 cycles then the ack cycle, `mem_addr`=0x100, `mem_we`=1111, `mem_wdata`=0xDEADBEEF.
   → One `rsp_valid` pulse, `rsp_err`=0, `rsp_rd`=0.
2. **Load sign/zero extension:** LB at 0x103, `rd`=5, `mem_rdata`=0x80FF1234.
   → `rsp_rdata`=0xFFFFFF80, `rsp_rd`=5.
   → LBU, same conditions → 0x00000080.
   → LH at 0x102 → 0xFFFF80FF.
3. **SH lane replication:** SH with `req_wdata`=0x1234ABCD at 0x102.
   → `mem_we`=1100, `mem_wdata`=0xABCDABCD, `mem_addr`=0x100.
4. **Misaligned and illegal:** LW at 0x102.
   → `mem_en` never asserts, `rsp_valid` 1 cycle after acceptance, code 01.
   → funct3=011 with `XLEN`=32 → code 11, no bus cycle.
5. **Timeout:** `TIMEOUT`=4, ack never asserted.
   → `mem_en` high exactly 4 cycles, then `rsp_valid` with code 10, `rsp_rdata`=0.
   → Repeat with ack in the 4th cycle → success, code 00.
6. **Reset mid-access:** `aresetn` low during ACCESS.
   → `mem_en`=0 immediately, no `rsp_valid`, `req_ready`=1.
   → `XLEN`=64, LD at 0x208 → `mem_we`=0 and full 64-bit `rsp_rdata`.
